// File: rtl/shift_sequencer_pkg.sv
// shift_seq_pkg: shared types and constants for the shift sequencer slice.
package shift_seq_pkg;
    localparam int SHIFTER_W = 8;
    localparam int PASS_MAX  = 7;
    localparam int PASS_W    = 3;
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: requester, response and barrel-shifter signals of the sequencer.
interface shift_sequencer_if
    import shift_seq_pkg::*;
#(
    parameter int SHAMT_W = 4
);
    logic                 req0_valid, req0_ready, req0_dir;
    logic [SHIFTER_W-1:0] req0_data;
    logic [SHAMT_W-1:0]   req0_shamt;
    logic                 req1_valid, req1_ready, req1_dir;
    logic [SHIFTER_W-1:0] req1_data;
    logic [SHAMT_W-1:0]   req1_shamt;
    logic                 resp_valid, resp_ready, resp_id;
    logic [SHIFTER_W-1:0] resp_data;
    logic [SHIFTER_W-1:0] bs_inp, bs_out;
    logic [PASS_W-1:0]    bs_shamt;
    logic                 bs_dir;

    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_dir,
        input  req1_valid, req1_data, req1_shamt, req1_dir,
        input  resp_ready, bs_out,
        output req0_ready, req1_ready, resp_valid, resp_data, resp_id,
        output bs_inp, bs_shamt, bs_dir
    );
    modport master (
        output req0_valid, req0_data, req0_shamt, req0_dir,
        output req1_valid, req1_data, req1_shamt, req1_dir,
        output resp_ready, bs_out,
        input  req0_ready, req1_ready, resp_valid, resp_data, resp_id,
        input  bs_inp, bs_shamt, bs_dir
    );
endinterface

// File: rtl/shift_sequencer_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter; the last-grant register lives in the parent.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       en_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       gid_o
);
    // On contention the side that did not win last time takes the grant.
    assign gnt_o[0] = en_i & valid_i[0] & (~valid_i[1] | last_i);
    assign gnt_o[1] = en_i & valid_i[1] & (~valid_i[0] | ~last_i);
    assign gid_o    = gnt_o[1];
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: shares one external 8-bit barrel shifter between two requesters,
// splitting wide shift amounts into passes of at most PASS_MAX bits.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int SHAMT_W = 4
) (
    input logic         clk,
    input logic         rst_n,
    shift_sequencer_if.slave bus
);
    state_t               state_q, state_d;
    logic [SHIFTER_W-1:0] work_q, work_d;
    logic [SHAMT_W-1:0]   rem_q, rem_d;
    logic                 dir_q, dir_d, id_q, id_d, last_q, last_d;
    logic [1:0]           gnt;
    logic                 gid;
    logic [PASS_W-1:0]    pass;
    logic                 in_shift, in_resp;

    rr_arb2 u_arb (
        .valid_i ({bus.req1_valid, bus.req0_valid}),
        .en_i    (state_q == IDLE),
        .last_i  (last_q),
        .gnt_o   (gnt),
        .gid_o   (gid)
    );

    assign in_shift = state_q == SHIFT;
    assign in_resp  = state_q == RESP;
    assign pass     = (rem_q > SHAMT_W'(PASS_MAX)) ? PASS_W'(PASS_MAX) : PASS_W'(rem_q);

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.resp_valid = in_resp;
    assign bus.resp_data  = in_resp ? work_q : '0;
    assign bus.resp_id    = in_resp & id_q;
    assign bus.bs_inp     = in_shift ? work_q : '0;
    assign bus.bs_shamt   = in_shift ? pass : '0;
    assign bus.bs_dir     = in_shift & dir_q;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        id_d    = id_q;
        last_d  = last_q;
        if (|gnt) begin
            work_d  = gid ? bus.req1_data : bus.req0_data;
            rem_d   = gid ? bus.req1_shamt : bus.req0_shamt;
            dir_d   = gid ? bus.req1_dir : bus.req0_dir;
            id_d    = gid;
            last_d  = gid;
            state_d = (rem_d == '0) ? RESP : SHIFT;
        end else if (in_shift) begin
            work_d  = bus.bs_out;
            rem_d   = rem_q - SHAMT_W'(pass);
            state_d = (rem_d == '0) ? RESP : SHIFT;
        end else if (in_resp && bus.resp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end
endmodule
